zigbee_deframer: RTL
====================

Name: zigbee_deframer

Overview:
- Receive-side PHY deframer directly downstream of outFIFO; consumes the CDR-recovered bitstream that outFIFO has packed into 4-bit nibbles.
- Hunts for the IEEE 802.15.4 synchronisation header (zero-nibble preamble, then SFD 0xA7), then extracts the 7-bit PHR frame length.
- Delivers payload bytes over a valid/ready handshake, with last-byte, frame-done and frame-error indications.

Parameters:
PREAMBLE_NIBBLES, 8, minimum consecutive 0x0 nibbles required before the SFD is accepted (range 1..15)
MAX_LEN, 127, largest accepted PHR length in bytes; PHR length 0 or greater than MAX_LEN is an error

Ports:
inClock  in  1  system clock
inReset  in  1  asynchronous, active-high reset
inEmpty  in  1  outFIFO empty flag
inData  in  4  outFIFO read data; valid the cycle after outReadEnable
outReadEnable  out  1  outFIFO read strobe, single-cycle pulse
outByte  out  8  payload byte
outByteValid  out  1  outByte valid; held until accepted
inByteReady  in  1  consumer accepts outByte when outByteValid && inByteReady
outLast  out  1  qualifies outByte as the final payload byte
outLength  out  7  PHR length of current frame; valid from leaving PHR_HI until next frame's PHR
outFrameDone  out  1  1-cycle pulse when the last byte is accepted
outFrameError  out  1  1-cycle pulse on bad PHR length

Behaviour:
- Reset is asynchronous and active-high (inReset). All outputs reset to 0, state = SEARCH, counters = 0, no read in flight.
- Read engine:
  - outReadEnable = !inEmpty && !rdPending && !byteHeld && state accepts nibbles.
  - rdPending is set the cycle after the strobe; the nibble is consumed that cycle, then rdPending clears.
  - At most one read is outstanding, so the maximum rate is 1 nibble per 2 cycles.
  - Never strobe while inEmpty = 1.
- Nibble order: low nibble first, then high nibble, for SFD, PHR and payload.
- State machine (advances only on a consumed nibble):
  - SEARCH: 0x0 increments zeroCnt (saturates at 15). 0x7 with zeroCnt >= PREAMBLE_NIBBLES goes to SFD_HI. Any other nibble sets zeroCnt = 0 and stays in SEARCH.
  - SFD_HI: 0xA goes to PHR_LO. Otherwise go to SEARCH with zeroCnt = (nibble == 0) ? 1 : 0.
  - PHR_LO: latch the nibble into len[3:0], go to PHR_HI.
  - PHR_HI: len[6:4] = nibble[2:0]; nibble[3] (reserved bit) is ignored.
    - If len == 0 or len > MAX_LEN: pulse outFrameError, outLength keeps its previous value, go to SEARCH with zeroCnt = 0.
    - Otherwise: outLength = len, byteCnt = 0, go to PAY_LO.
  - PAY_LO: latch the low nibble, go to PAY_HI.
  - PAY_HI: outByte = {nibble, low}, outByteValid = 1, outLast = (byteCnt == len-1), go to HOLD.
  - HOLD: no reads issued. On inByteReady: outByteValid = 0, outLast = 0, byteCnt++.
    - If the byte was last: pulse outFrameDone in the same cycle, go to SEARCH with zeroCnt = 0.
    - Otherwise go to PAY_LO.
- outByteValid rises the cycle after the high nibble is consumed. outByte and outLast are stable while valid && !ready.
- inByteReady held high: the next byte appears no earlier than 4 cycles after acceptance.
- A 0x0 nibble inside the payload has no special meaning. There is no re-sync until the frame completes.
- inReset mid-frame aborts immediately: outputs return to 0 and no outFrameDone or outFrameError is produced.
- inEmpty mid-frame: the engine waits indefinitely, with no timeout.

Decomposition:
- Package zigbee_pkg holds:
  - the state enum (SEARCH, SFD_HI, PHR_LO, PHR_HI, PAY_LO, PAY_HI, HOLD);
  - SFD_LO_NIB = 4'h7 and SFD_HI_NIB = 4'hA;
  - PHR_LEN_W = 7.
- Sub-module fifo_nibble_reader contains the one-outstanding read engine.
  - Inputs: inClock, inReset, inEmpty, inData, enable.
  - Outputs: outReadEnable, nibble, nibbleValid.
- The deframer FSM instantiates fifo_nibble_reader.

Test Plan:
- Preamble, SFD and a 2-byte frame:
  - Stimulus: FIFO holds 0,0,0,0,0,0,0,0,7,A,2,0,4,3,D,C, inByteReady = 1.
  - Response: outLength = 2; bytes 0x34 then 0xCD; outLast only on 0xCD; one outFrameDone; no outFrameError.
- Short preamble:
  - Stimulus: seven 0x0 nibbles then 7,A,...
  - Response: no frame. Then eight 0x0, 7,A,1,0,F,F gives a single byte 0xFF with outLast.
- Bad length:
  - Stimulus: sync, then PHR nibbles 0,0 (len 0).
  - Response: one outFrameError pulse, no outByteValid. Repeat with F,F and MAX_LEN = 127 → len 127 accepted, since bit 7 is ignored.
- Backpressure:
  - Stimulus: 3-byte frame, inByteReady low for 10 cycles on byte 2.
  - Response: outByte held stable; no outReadEnable during the hold; all bytes in order, each once.
- Empty FIFO:
  - Stimulus: inEmpty asserted between every nibble for random gaps.
  - Response: outReadEnable never asserted while inEmpty = 1; output bytes unchanged versus the gapless run.
- Reset mid-frame:
  - Stimulus: inReset pulsed during PAY_HI.
  - Response: outputs go to 0 immediately, no done or error pulse; a subsequent full frame decodes correctly.

Source files
------------

// File: rtl/zigbee_pkg.sv
// Shared types and constants for the 802.15.4 receive deframer.
package zigbee_pkg;

  typedef enum logic [2:0] {
    SEARCH,
    SFD_HI,
    PHR_LO,
    PHR_HI,
    PAY_LO,
    PAY_HI,
    HOLD
  } state_e;

  localparam logic [3:0] SFD_LO_NIB = 4'h7;
  localparam logic [3:0] SFD_HI_NIB = 4'hA;
  localparam int unsigned PHR_LEN_W = 7;

  // PHR length is legal when non-zero and no larger than the configured maximum.
  function automatic logic len_ok(input logic [PHR_LEN_W-1:0] len, input logic [7:0] max_len);
    return (len != '0) && ({1'b0, len} <= max_len);
  endfunction

endpackage

// File: rtl/fifo_nibble_reader.sv
// One-outstanding read engine in front of outFIFO; data returns the cycle after the strobe.
module fifo_nibble_reader (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inEmpty,
  input  logic [3:0] inData,
  input  logic       enable,
  output logic       outReadEnable,
  output logic [3:0] nibble,
  output logic       nibbleValid
);

  logic r_pending;
  logic w_strobe;

  assign w_strobe = enable && !inEmpty && !r_pending;

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_strobe;
    end
  end

  assign outReadEnable = w_strobe;
  assign nibbleValid   = r_pending;
  assign nibble        = inData;

endmodule

// File: rtl/zigbee_deframer.sv
// Hunts for preamble + SFD, extracts the PHR length and streams payload bytes out.
module zigbee_deframer
  import zigbee_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBBLES = 8,
  parameter int unsigned MAX_LEN          = 127
) (
  input  logic                 inClock,
  input  logic                 inReset,
  input  logic                 inEmpty,
  input  logic [3:0]           inData,
  output logic                 outReadEnable,
  output logic [7:0]           outByte,
  output logic                 outByteValid,
  input  logic                 inByteReady,
  output logic                 outLast,
  output logic [PHR_LEN_W-1:0] outLength,
  output logic                 outFrameDone,
  output logic                 outFrameError
);

  localparam logic [3:0] PreambleMin = 4'(PREAMBLE_NIBBLES);
  localparam logic [7:0] MaxLen      = 8'(MAX_LEN);

  state_e               r_state,      w_state_next;
  logic [3:0]           r_zero_cnt,   w_zero_next;
  logic [PHR_LEN_W-1:0] r_len,        w_len_next;
  logic [3:0]           r_low,        w_low_next;
  logic [PHR_LEN_W-1:0] r_byte_cnt,   w_cnt_next;
  logic [7:0]           r_byte,       w_byte_next;
  logic                 r_byte_valid, w_valid_next;
  logic                 r_last,       w_last_next;
  logic [PHR_LEN_W-1:0] r_length,     w_length_next;

  logic                 w_enable;
  logic                 w_nib_valid;
  logic [3:0]           w_nib;
  logic [PHR_LEN_W-1:0] w_len_full;
  logic                 w_frame_done;
  logic                 w_frame_error;

  // Reads stop while a byte is waiting and while reset holds the outputs at zero.
  assign w_enable   = (r_state != HOLD) && !inReset;
  assign w_len_full = {w_nib[2:0], r_len[3:0]};

  fifo_nibble_reader u_reader (
    .inClock       (inClock),
    .inReset       (inReset),
    .inEmpty       (inEmpty),
    .inData        (inData),
    .enable        (w_enable),
    .outReadEnable (outReadEnable),
    .nibble        (w_nib),
    .nibbleValid   (w_nib_valid)
  );

  always_comb begin
    w_state_next  = r_state;
    w_zero_next   = r_zero_cnt;
    w_len_next    = r_len;
    w_low_next    = r_low;
    w_cnt_next    = r_byte_cnt;
    w_byte_next   = r_byte;
    w_valid_next  = r_byte_valid;
    w_last_next   = r_last;
    w_length_next = r_length;
    w_frame_done  = 1'b0;
    w_frame_error = 1'b0;

    unique case (r_state)
      SEARCH: begin
        if (w_nib_valid) begin
          if (w_nib == 4'h0) begin
            if (r_zero_cnt != 4'hF) w_zero_next = r_zero_cnt + 4'd1;
          end else if (w_nib == SFD_LO_NIB && r_zero_cnt >= PreambleMin) begin
            w_state_next = SFD_HI;
            w_zero_next  = '0;
          end else begin
            w_zero_next = '0;
          end
        end
      end
      SFD_HI: begin
        if (w_nib_valid) begin
          if (w_nib == SFD_HI_NIB) begin
            w_state_next = PHR_LO;
          end else begin
            // A zero here may be the start of a fresh preamble.
            w_state_next = SEARCH;
            w_zero_next  = (w_nib == 4'h0) ? 4'd1 : 4'd0;
          end
        end
      end
      PHR_LO: begin
        if (w_nib_valid) begin
          w_len_next   = {3'b000, w_nib};
          w_state_next = PHR_HI;
        end
      end
      PHR_HI: begin
        if (w_nib_valid) begin
          if (!len_ok(w_len_full, MaxLen)) begin
            w_frame_error = 1'b1;
            w_state_next  = SEARCH;
            w_zero_next   = '0;
          end else begin
            w_len_next    = w_len_full;
            w_length_next = w_len_full;
            w_cnt_next    = '0;
            w_state_next  = PAY_LO;
          end
        end
      end
      PAY_LO: begin
        if (w_nib_valid) begin
          w_low_next   = w_nib;
          w_state_next = PAY_HI;
        end
      end
      PAY_HI: begin
        if (w_nib_valid) begin
          w_byte_next  = {w_nib, r_low};
          w_valid_next = 1'b1;
          w_last_next  = (r_byte_cnt == (r_len - 7'd1));
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (inByteReady) begin
          w_valid_next = 1'b0;
          w_last_next  = 1'b0;
          w_cnt_next   = r_byte_cnt + 7'd1;
          if (r_last) begin
            w_frame_done = 1'b1;
            w_state_next = SEARCH;
            w_zero_next  = '0;
          end else begin
            w_state_next = PAY_LO;
          end
        end
      end
      default: begin
        w_state_next = SEARCH;
        w_zero_next  = '0;
      end
    endcase
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      r_state      <= SEARCH;
      r_zero_cnt   <= '0;
      r_len        <= '0;
      r_low        <= '0;
      r_byte_cnt   <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_last       <= 1'b0;
      r_length     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_zero_cnt   <= w_zero_next;
      r_len        <= w_len_next;
      r_low        <= w_low_next;
      r_byte_cnt   <= w_cnt_next;
      r_byte       <= w_byte_next;
      r_byte_valid <= w_valid_next;
      r_last       <= w_last_next;
      r_length     <= w_length_next;
    end
  end

  assign outByte       = r_byte;
  assign outByteValid  = r_byte_valid;
  assign outLast       = r_last;
  assign outLength     = r_length;
  assign outFrameDone  = w_frame_done;
  assign outFrameError = w_frame_error;

endmodule
